// File: rtl/packed_slice_assembler_if.sv
// Valid/ready bundle between a slice source, the packed slice assembler and its consumer.
// Latency: none; wires only.
// Backpressure: in_ready_pl throttles the slice source, out_ready_pl throttles the word output.
// Ports: in_valid_pl/in_ready_pl/in_slice_pl/in_flush_pl form the slice stream,
//   out_valid_pl/out_ready_pl/out_word_pl/out_bit_pl form the word stream,
//   beat_cnt_pl/word_cnt_pl are status counters.
// master = slice source / word sink, slave = assembler.
interface packed_slice_assembler_if #(
  parameter int SLICE_W = 2,
  parameter int WORD_W  = 10,
  parameter int CNT_W   = 8
);
  localparam int BEAT_W = $clog2(WORD_W / SLICE_W) + 1;

  logic               in_valid_pl;
  logic               in_ready_pl;
  logic [SLICE_W-1:0] in_slice_pl;
  logic               in_flush_pl;
  logic               out_valid_pl;
  logic               out_ready_pl;
  logic [WORD_W-1:0]  out_word_pl;
  logic               out_bit_pl;
  logic [BEAT_W-1:0]  beat_cnt_pl;
  logic [CNT_W-1:0]   word_cnt_pl;

  modport master (
    output in_valid_pl, in_slice_pl, in_flush_pl, out_ready_pl,
    input  in_ready_pl, out_valid_pl, out_word_pl, out_bit_pl, beat_cnt_pl, word_cnt_pl
  );

  modport slave (
    input  in_valid_pl, in_slice_pl, in_flush_pl, out_ready_pl,
    output in_ready_pl, out_valid_pl, out_word_pl, out_bit_pl, beat_cnt_pl, word_cnt_pl
  );
endinterface

// File: rtl/packed_slice_assembler.sv
// Packs WORD_W/SLICE_W narrow slices (LS field first) into one word plus an override bit.
// Latency: out_valid_pl rises on the edge accepting the last slice; one word per BEATS+1 cycles at best.
// Backpressure: in_ready_pl drops while a finished word is held; the word holds until out_ready_pl.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries slice stream, word stream
//   and the beat/word counters.
// Option: define PACKED_ASM_PARITY_EN to make out_bit_pl the XOR of the word instead of its bit 0.
module packed_slice_assembler #(
  parameter int SLICE_W = 2,
  parameter int WORD_W  = 10,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  packed_slice_assembler_if.slave bus
);
  localparam int BEATS  = WORD_W / SLICE_W;
  localparam int BEAT_W = $clog2(BEATS) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (WORD_W % SLICE_W != 0) begin : g_bad_width
    $error("packed_slice_assembler: WORD_W must be a multiple of SLICE_W");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

  state_t             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  word_nxt;
  logic               bit_q;
  logic               bit_nxt;
  logic               valid_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic               in_rdy;
  logic               drop;
  logic               take;

  // Ready is gated by rst_n so the source sees no handshake while reset is held.
  assign in_rdy = rst_n && (state_q != FULL);
  // A flush while filling swallows any slice offered in the same cycle.
  assign drop   = (state_q == FILL) && bus.in_flush_pl;
  assign take   = bus.in_valid_pl && in_rdy && !drop;

  // Only the field addressed by beat_q changes; other fields keep stale data.
  always_comb begin
    word_nxt = word_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        word_nxt[k*SLICE_W +: SLICE_W] = bus.in_slice_pl;
      end
    end
  end

`ifdef PACKED_ASM_PARITY_EN
  assign bit_nxt = ^word_nxt;
`else
  assign bit_nxt = word_nxt[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (drop) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else if (take) begin
            word_q <= word_nxt;
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              state_q <= FULL;
              valid_q <= 1'b1;
              bit_q   <= bit_nxt;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FULL: begin
          if (bus.out_ready_pl) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            beat_q  <= '0;
            wcnt_q  <= wcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          beat_q  <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready_pl  = in_rdy;
  assign bus.out_valid_pl = valid_q;
  assign bus.out_word_pl  = word_q;
  assign bus.out_bit_pl   = bit_q;
  assign bus.beat_cnt_pl  = beat_q;
  assign bus.word_cnt_pl  = wcnt_q;
endmodule

// File: tb/tb_packed_slice_assembler.sv
// Bench for packed_slice_assembler: directed scenarios plus randomized words, checked by a
// queue-based reference model and an independent output monitor.
module tb_packed_slice_assembler;
  localparam int SLICE_W = 2;
  localparam int WORD_W  = 10;
  localparam int CNT_W   = 8;
  localparam int BEATS   = WORD_W / SLICE_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packed_slice_assembler_if #(.SLICE_W(SLICE_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  packed_slice_assembler #(.SLICE_W(SLICE_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              b;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic model_bit(input logic [WORD_W-1:0] w);
`ifdef PACKED_ASM_PARITY_EN
    return ^w;
`else
    return w[0];
`endif
  endfunction

  // Reference model: tracks slices held and the persistent word contents.
  int                m_cnt = 0;
  bit                m_full = 0;
  logic [WORD_W-1:0] m_word = '0;
  exp_t              m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_full = 0;
      m_word = '0;
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(bus.in_ready_pl), 32'(!m_full));
      chk("out_valid", 32'(bus.out_valid_pl), 32'(m_full));
      chk("beat_cnt", 32'(bus.beat_cnt_pl), 32'(m_cnt));
      if (m_full) begin
        if (!bus.out_ready_pl) begin
          if (exp_q.size() > 0) chk("held_word", 32'(bus.out_word_pl), 32'(exp_q[0].word));
        end else begin
          m_full = 0;
          m_cnt = 0;
        end
      end else if (bus.in_flush_pl && m_cnt > 0) begin
        m_cnt = 0;
      end else if (bus.in_valid_pl) begin
        m_word = (m_word & ~(WORD_W'((1 << SLICE_W) - 1) << (m_cnt * SLICE_W)))
               | (WORD_W'(bus.in_slice_pl) << (m_cnt * SLICE_W));
        m_cnt++;
        if (m_cnt == BEATS) begin
          m_full = 1;
          m_e.word = m_word;
          m_e.b = model_bit(m_word);
          exp_q.push_back(m_e);
        end
      end
    end
  end

  // Monitor: compares each handed-off word with the oldest expectation.
  int   exp_wcnt = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_wcnt = 0;
    end else if (bus.out_valid_pl && bus.out_ready_pl) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h with no word expected at %0t", bus.out_word_pl, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_word", 32'(bus.out_word_pl), 32'(mon_e.word));
        chk("out_bit", 32'(bus.out_bit_pl), 32'(mon_e.b));
        chk("word_cnt", 32'(bus.word_cnt_pl), 32'(exp_wcnt));
        exp_wcnt = (exp_wcnt + 1) % (1 << CNT_W);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SLICE_W-1:0] s);
    bit ok;
    int n;
    n = 0;
    bus.in_valid_pl = 1'b1;
    bus.in_slice_pl = s;
    do begin
      @(negedge clk);
      ok = bus.in_ready_pl;
      tick();
      n++;
    end while (!ok && n < 100);
    if (!ok) fail("send");
  endtask

  task automatic idle(input int n);
    bus.in_valid_pl = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_out();
    bit ok;
    int n;
    n = 0;
    do begin
      bus.out_ready_pl = 1'($urandom_range(1, 0));
      @(negedge clk);
      ok = bus.out_valid_pl && bus.out_ready_pl;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) fail("wait_out");
  endtask

  initial begin
    bus.in_valid_pl  = 1'b0;
    bus.in_slice_pl  = '0;
    bus.in_flush_pl  = 1'b0;
    bus.out_ready_pl = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready_pl), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_pl), 32'd0);
    chk("rst_beat_cnt", 32'(bus.beat_cnt_pl), 32'd0);
    chk("rst_word_cnt", 32'(bus.word_cnt_pl), 32'd0);
    chk("rst_out_word", 32'(bus.out_word_pl), 32'd0);
    chk("rst_out_bit", 32'(bus.out_bit_pl), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fill: 01,10,11,00,01 -> 10'h139
    bus.out_ready_pl = 1'b1;
    send(2'b01); send(2'b10); send(2'b11); send(2'b00); send(2'b01);
    bus.in_valid_pl = 1'b0;
    chk("fill_valid", 32'(bus.out_valid_pl), 32'd1);
    chk("fill_word", 32'(bus.out_word_pl), 32'h139);
    chk("fill_bit", 32'(bus.out_bit_pl), 32'd1);
    tick();
    chk("fill_word_cnt", 32'(bus.word_cnt_pl), 32'd1);

    // Backpressure: word held for 4 cycles while another slice is offered
    bus.out_ready_pl = 1'b0;
    for (int i = 0; i < BEATS; i++) send(SLICE_W'($urandom_range(3, 0)));
    bus.in_valid_pl = 1'b1;
    bus.in_slice_pl = 2'b11;
    repeat (4) tick();
    chk("bp_in_ready", 32'(bus.in_ready_pl), 32'd0);
    bus.out_ready_pl = 1'b1;
    tick();
    chk("bp_word_cnt", 32'(bus.word_cnt_pl), 32'd2);
    tick();
    bus.in_valid_pl = 1'b0;
    chk("bp_held_slice_taken", 32'(bus.beat_cnt_pl), 32'd1);

    // Flush after 3 slices, with a slice offered in the flush cycle
    send(2'b10); send(2'b01);
    bus.in_flush_pl = 1'b1;
    bus.in_valid_pl = 1'b1;
    bus.in_slice_pl = 2'b01;
    tick();
    bus.in_flush_pl = 1'b0;
    bus.in_valid_pl = 1'b0;
    chk("flush_beat_cnt", 32'(bus.beat_cnt_pl), 32'd0);
    for (int i = 0; i < BEATS; i++) send(2'b11);
    bus.in_valid_pl = 1'b0;
    chk("flush_word", 32'(bus.out_word_pl), 32'h3FF);
`ifdef PACKED_ASM_PARITY_EN
    chk("flush_bit", 32'(bus.out_bit_pl), 32'd0);
`else
    chk("flush_bit", 32'(bus.out_bit_pl), 32'd1);
`endif
    tick();

    // Flush while a word is held must not discard it
    bus.out_ready_pl = 1'b0;
    for (int i = 0; i < BEATS; i++) send(SLICE_W'($urandom_range(3, 0)));
    bus.in_valid_pl = 1'b0;
    bus.in_flush_pl = 1'b1;
    tick();
    tick();
    bus.in_flush_pl = 1'b0;
    chk("full_flush_valid", 32'(bus.out_valid_pl), 32'd1);
    bus.out_ready_pl = 1'b1;
    tick();
    chk("full_flush_word_cnt", 32'(bus.word_cnt_pl), 32'd4);

    // Async reset mid-word, between clock edges
    send(2'b11); send(2'b11);
    bus.in_valid_pl = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid_pl), 32'd0);
    chk("arst_beat_cnt", 32'(bus.beat_cnt_pl), 32'd0);
    chk("arst_out_word", 32'(bus.out_word_pl), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready_pl), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Counter wrap: 256 random words with random gaps and backpressure
    for (int w = 0; w < (1 << CNT_W); w++) begin
      for (int b = 0; b < BEATS; b++) begin
        if ($urandom_range(3, 0) == 0) idle(1);
        bus.out_ready_pl = 1'($urandom_range(1, 0));
        send(SLICE_W'($urandom_range(3, 0)));
      end
      bus.in_valid_pl = 1'b0;
      wait_out();
    end
    chk("wrap_word_cnt", 32'(bus.word_cnt_pl), 32'd0);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
